// File: rtl/param_seq_alu.sv
// param_seq_alu: clocked WIDTH-bit ALU with a shift-add multiplier, an internal CCR and a CCR save stack.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  issue handshake; in_ready is high only while idle
//   op                   5-bit operation code; codes 19-31 behave as NOP
//   operand_a/operand_b  WIDTH-bit operands (b is also the shift amount)
//   out_valid            one-cycle completion pulse
//   result_lo/result_hi  result, high half non-zero only for MUL
//   ccr                  {NF, OF, CF, ZF}
//   ccr_err              sticky save-stack overflow/underflow flag
module param_seq_alu #(
    parameter int WIDTH      = 16,
    parameter int SAVE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       ccr,
    output logic             ccr_err
);
    localparam int CW = $clog2(WIDTH);
    localparam int SW = $clog2(SAVE_DEPTH + 1);
    localparam int IW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;
    localparam logic [4:0] OP_NOT  = 5'd1;
    localparam logic [4:0] OP_INC  = 5'd2;
    localparam logic [4:0] OP_DEC  = 5'd3;
    localparam logic [4:0] OP_MOV  = 5'd4;
    localparam logic [4:0] OP_ADD  = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_SHR  = 5'd10;
    localparam logic [4:0] OP_SETC = 5'd11;
    localparam logic [4:0] OP_CLRC = 5'd12;
    localparam logic [4:0] OP_MUL  = 5'd13;
    localparam logic [4:0] OP_SAVE = 5'd14;
    localparam logic [4:0] OP_RTI  = 5'd15;
    localparam logic [4:0] OP_JZ   = 5'd16;
    localparam logic [4:0] OP_JN   = 5'd17;
    localparam logic [4:0] OP_JC   = 5'd18;

    typedef enum logic {IDLE, MULT} state_t;
    state_t state, stateNext;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accSum;
    logic [3:0]         stack [SAVE_DEPTH];
    logic [SW-1:0]      sp;
    logic               accept;
    logic               mulLast;
    logic               stackFull;
    logic               stackEmpty;
    logic [WIDTH:0]     aluWide;
    logic [WIDTH-1:0]   aluRes;
    logic [3:0]         aluCcr;
    logic               setZn;

    assign in_ready   = state == IDLE;
    assign accept     = in_valid && in_ready;
    assign mulLast    = (state == MULT) && (count == CW'(WIDTH - 1));
    assign stackFull  = sp == SW'(SAVE_DEPTH);
    assign stackEmpty = sp == '0;
    assign accSum     = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (accept && op == OP_MUL) stateNext = MULT;
        if (mulLast)                stateNext = IDLE;
    end

    // Single-cycle ALU path; shifts run one bit wider so the last bit shifted out lands in CF.
    always_comb begin
        aluWide = '0;
        aluRes  = '0;
        aluCcr  = ccr;
        setZn   = 1'b0;
        case (op)
            OP_NOT: begin
                aluRes = ~operand_a;
                setZn  = 1'b1;
            end
            OP_INC: begin
                aluWide   = {1'b0, operand_a} + (WIDTH + 1)'(1);
                aluRes    = aluWide[WIDTH-1:0];
                aluCcr[1] = aluWide[WIDTH];
                setZn     = 1'b1;
            end
            OP_DEC: begin
                aluWide   = {1'b0, operand_a} - (WIDTH + 1)'(1);
                aluRes    = aluWide[WIDTH-1:0];
                aluCcr[1] = aluWide[WIDTH];
                setZn     = 1'b1;
            end
            OP_MOV: aluRes = operand_b;
            OP_ADD: begin
                aluWide   = {1'b0, operand_a} + {1'b0, operand_b};
                aluRes    = aluWide[WIDTH-1:0];
                aluCcr[1] = aluWide[WIDTH];
                aluCcr[2] = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (aluWide[WIDTH-1] != operand_a[WIDTH-1]);
                setZn     = 1'b1;
            end
            OP_SUB: begin
                aluWide   = {1'b0, operand_a} - {1'b0, operand_b};
                aluRes    = aluWide[WIDTH-1:0];
                aluCcr[1] = aluWide[WIDTH];
                aluCcr[2] = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (aluWide[WIDTH-1] != operand_a[WIDTH-1]);
                setZn     = 1'b1;
            end
            OP_AND: begin
                aluRes = operand_a & operand_b;
                setZn  = 1'b1;
            end
            OP_OR: begin
                aluRes = operand_a | operand_b;
                setZn  = 1'b1;
            end
            OP_SHL: begin
                aluWide   = {1'b0, operand_a} << operand_b;
                aluRes    = aluWide[WIDTH-1:0];
                aluCcr[1] = aluWide[WIDTH];
                setZn     = 1'b1;
            end
            OP_SHR: begin
                aluWide   = {operand_a, 1'b0} >> operand_b;
                aluRes    = aluWide[WIDTH:1];
                aluCcr[1] = aluWide[0];
                setZn     = 1'b1;
            end
            OP_SETC: aluCcr[1] = 1'b1;
            OP_CLRC: aluCcr[1] = 1'b0;
            OP_RTI:  aluCcr    = stackEmpty ? ccr : stack[IW'(sp - SW'(1))];
            OP_JZ:   aluCcr[0] = 1'b0;
            OP_JN:   aluCcr[3] = 1'b0;
            OP_JC:   aluCcr[1] = 1'b0;
            default: aluRes = '0;
        endcase
        if (setZn) begin
            aluCcr[0] = aluRes == '0;
            aluCcr[3] = aluRes[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            ccr       <= '0;
            ccr_err   <= 1'b0;
            sp        <= '0;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            for (int i = 0; i < SAVE_DEPTH; i++) stack[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept && op == OP_MUL) begin
                mcand  <= {{WIDTH{1'b0}}, operand_a};
                mplier <= operand_b;
                acc    <= '0;
                count  <= '0;
            end else if (accept) begin
                out_valid <= 1'b1;
                result_lo <= aluRes;
                result_hi <= '0;
                ccr       <= aluCcr;
                if (op == OP_SAVE) begin
                    if (stackFull) begin
                        ccr_err <= 1'b1;
                    end else begin
                        stack[IW'(sp)] <= ccr;
                        sp             <= sp + SW'(1);
                    end
                end
                if (op == OP_RTI) begin
                    if (stackEmpty) ccr_err <= 1'b1;
                    else            sp      <= sp - SW'(1);
                end
            end else if (state == MULT) begin
                acc    <= accSum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
                if (mulLast) begin
                    out_valid <= 1'b1;
                    result_lo <= accSum[WIDTH-1:0];
                    result_hi <= accSum[2*WIDTH-1:WIDTH];
                    ccr       <= {accSum[2*WIDTH-1], ccr[2], accSum[2*WIDTH-1:WIDTH] != '0, accSum == '0};
                end
            end
        end
    end
endmodule

// File: tb/tb_param_seq_alu.sv
// tb_param_seq_alu: directed-vector bench for param_seq_alu at WIDTH=16, SAVE_DEPTH=2.
module tb_param_seq_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [15:0] operand_a = '0;
    logic [15:0] operand_b = '0;
    logic        out_valid;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic [3:0]  ccr;
    logic        ccr_err;
    int          vecCount = 0;
    int          missCount = 0;

    param_seq_alu #(.WIDTH(16), .SAVE_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
        .result_lo(result_lo), .result_hi(result_hi), .ccr(ccr), .ccr_err(ccr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [3:0]  c;
    } vec_t;

    vec_t tbl [22] = '{
        '{5'd5,  16'h7FFF, 16'h0001, 16'h8000, 4'b1100},
        '{5'd6,  16'h0000, 16'h0001, 16'hFFFF, 4'b1010},
        '{5'd10, 16'h0003, 16'd1,    16'h0001, 4'b0010},
        '{5'd9,  16'h8001, 16'd20,   16'h0000, 4'b0001},
        '{5'd9,  16'h8001, 16'd1,    16'h0002, 4'b0010},
        '{5'd9,  16'h0001, 16'd16,   16'h0000, 4'b0011},
        '{5'd10, 16'h8000, 16'd16,   16'h0000, 4'b0011},
        '{5'd10, 16'h8000, 16'd17,   16'h0000, 4'b0001},
        '{5'd1,  16'h00FF, 16'h0000, 16'hFF00, 4'b1000},
        '{5'd7,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000},
        '{5'd8,  16'h8000, 16'h0001, 16'h8001, 4'b1000},
        '{5'd4,  16'h5555, 16'h1234, 16'h1234, 4'b1000},
        '{5'd3,  16'h0000, 16'h0000, 16'hFFFF, 4'b1010},
        '{5'd2,  16'hFFFF, 16'h0000, 16'h0000, 4'b0011},
        '{5'd5,  16'h8000, 16'h8000, 16'h0000, 4'b0111},
        '{5'd16, 16'h0000, 16'h0000, 16'h0000, 4'b0110},
        '{5'd6,  16'h8000, 16'h0001, 16'h7FFF, 4'b0100},
        '{5'd6,  16'h0000, 16'h0001, 16'hFFFF, 4'b1010},
        '{5'd17, 16'h0000, 16'h0000, 16'h0000, 4'b0010},
        '{5'd18, 16'h0000, 16'h0000, 16'h0000, 4'b0000},
        '{5'd11, 16'h0000, 16'h0000, 16'h0000, 4'b0010},
        '{5'd12, 16'h0000, 16'h0000, 16'h0000, 4'b0000}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitOut(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 40);
    endtask

    task automatic runMul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] prod, input logic [3:0] c);
        int n;
        issue(5'd13, a, b);
        check({tag, ".busy"}, {31'd0, in_ready}, 32'd0);
        waitOut(n);
        check({tag, ".lat"}, n, 32'd16);
        check({tag, ".prod"}, {result_hi, result_lo}, prod);
        check({tag, ".ccr"}, {28'd0, ccr}, {28'd0, c});
    endtask

    initial begin
        int n;
        #12;
        check("rst.ready", {31'd0, in_ready}, 32'd1);
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.res", {result_hi, result_lo}, 32'd0);
        check("rst.ccr", {27'd0, ccr_err, ccr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            check($sformatf("v%0d.valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d.res", i), {result_hi, result_lo}, {16'd0, tbl[i].r});
            check($sformatf("v%0d.ccr", i), {28'd0, ccr}, {28'd0, tbl[i].c});
        end
        @(posedge clk);
        #1;
        check("pulse.end", {31'd0, out_valid}, 32'd0);
        check("pulse.hold", {16'd0, result_lo}, 32'd0);

        issue(5'd13, 16'hFFFF, 16'hFFFF);
        check("mulff.busy", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b1;
        op        = 5'd5;
        operand_a = 16'd1;
        operand_b = 16'd2;
        waitOut(n);
        check("mulff.lat", n, 32'd16);
        check("mulff.ready", {31'd0, in_ready}, 32'd1);
        check("mulff.prod", {result_hi, result_lo}, 32'hFFFE0001);
        check("mulff.ccr", {28'd0, ccr}, 32'b1010);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("stall.valid", {31'd0, out_valid}, 32'd1);
        check("stall.res", {result_hi, result_lo}, 32'd3);
        check("stall.ccr", {28'd0, ccr}, 32'd0);
        @(posedge clk);
        #1;
        check("stall.once", {31'd0, out_valid}, 32'd0);

        issue(5'd11, 16'd0, 16'd0);
        issue(5'd14, 16'd0, 16'd0);
        issue(5'd12, 16'd0, 16'd0);
        issue(5'd14, 16'd0, 16'd0);
        issue(5'd11, 16'd0, 16'd0);
        check("stk.setc", {28'd0, ccr}, 32'b0010);
        issue(5'd15, 16'd0, 16'd0);
        check("stk.rti1", {27'd0, ccr_err, ccr}, 32'b00000);
        issue(5'd15, 16'd0, 16'd0);
        check("stk.rti2", {27'd0, ccr_err, ccr}, 32'b00010);
        issue(5'd15, 16'd0, 16'd0);
        check("stk.under", {27'd0, ccr_err, ccr}, 32'b10010);

        issue(5'd13, 16'd3, 16'd5);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #2;
        check("abort.ready", {31'd0, in_ready}, 32'd1);
        check("abort.state", {26'd0, out_valid, ccr_err, ccr}, 32'd0);
        check("abort.res", {result_hi, result_lo}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) n++;
        end
        check("abort.nopulse", n, 32'd0);

        issue(5'd14, 16'd0, 16'd0);
        issue(5'd14, 16'd0, 16'd0);
        check("ovf.ok", {31'd0, ccr_err}, 32'd0);
        issue(5'd14, 16'd0, 16'd0);
        check("ovf.err", {31'd0, ccr_err}, 32'd1);

        runMul("mul1", 16'h1234, 16'h0010, 32'h00012340, 4'b0010);
        runMul("mul0", 16'h0000, 16'hFFFF, 32'h00000000, 4'b0001);
        runMul("mul2", 16'h00FF, 16'h0101, 32'h0000FFFF, 4'b0000);

        issue(5'd11, 16'd0, 16'd0);
        issue(5'd25, 16'h0005, 16'h0007);
        check("nop25.valid", {31'd0, out_valid}, 32'd1);
        check("nop25.res", {result_hi, result_lo}, 32'd0);
        check("nop25.ccr", {28'd0, ccr}, 32'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/param_seq_alu.md
# param_seq_alu

Parametrised, clocked successor of the processor's combinational ALU. It executes the same operation set at WIDTH bits and adds an unsigned multi-cycle multiplier with a double-width result. It owns the condition-code register (CCR) internally, along with a SAVE_DEPTH-deep CCR save stack for nested interrupts. It sits in the execute stage behind a valid/ready handshake and stalls issue while a multiply is in flight.

## Interface
- WIDTH, 16, operand/result width (>= 4)
- SAVE_DEPTH, 2, number of CCR snapshots held for nested interrupts (>= 1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  op/operands valid this cycle
- in_ready  out  1  block can accept; equals (state == IDLE)
- op  in  5  operation code (see Operation)
- operand_a  in  WIDTH  first operand (Rdst)
- operand_b  in  WIDTH  second operand (Rsrc / shift amount)
- out_valid  out  1  one-cycle pulse: result_lo/result_hi/ccr reflect the completed op
- result_lo  out  WIDTH  result (low half for MUL)
- result_hi  out  WIDTH  MUL high half; 0 for all other ops
- ccr  out  4  flags {NF, OF, CF, ZF} = bits [3:0]
- ccr_err  out  1  sticky: save-stack overflow or underflow occurred

## Operation
- Accept when in_valid && in_ready. Only accepted ops update state.
- Codes: 0 NOP, 1 NOT, 2 INC, 3 DEC, 4 MOV, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 SHL, 10 SHR, 11 SETC, 12 CLRC, 13 MUL, 14 SAVE, 15 RTI, 16 JZ, 17 JN, 18 JC.
- Codes 19–31 execute as NOP.
- Flag notation: Z = (result_lo == 0); N = result_lo[WIDTH-1]. Flags not listed stay unchanged.
- NOT: ~a; updates Z, N.
- MOV: b; flags unchanged.
- AND, OR: a&b and a|b; update Z, N.
- INC, DEC: a+1 and a-1, computed in WIDTH+1 bits. Update Z, N; CF = bit WIDTH (carry out / borrow).
- ADD: a+b in WIDTH+1 bits. CF = carry out; OF = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); updates Z, N.
- SUB: a-b in WIDTH+1 bits. CF = borrow (bit WIDTH); OF = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); updates Z, N.
- SHL: a << b.
  - b = 0: CF = 0.
  - 1 <= b <= WIDTH: CF = a[WIDTH-b].
  - b > WIDTH: result 0, CF = 0.
  - Updates Z, N.
- SHR: logical a >> b.
  - b = 0: CF = 0.
  - 1 <= b <= WIDTH: CF = a[b-1].
  - b > WIDTH: result 0, CF = 0.
  - Updates Z, N.
- SETC, CLRC: CF = 1 and CF = 0 respectively; result 0.
- JZ, JN, JC: clear ZF, NF and CF respectively; result 0.
- MUL: unsigned a*b as a 2*WIDTH product, computed by shift-add, one bit per cycle.
  - {result_hi, result_lo} = product.
  - ZF = (product == 0); NF = product[2W-1]; CF = (result_hi != 0); OF unchanged.
- SAVE: push current CCR onto the stack; result 0; CCR unchanged.
  - Stack full: no push, ccr_err <= 1.
- RTI: pop the stack into CCR; result 0.
  - Stack empty: CCR unchanged, ccr_err <= 1.
- States:
  - IDLE: every op except MUL completes at the accept edge. MUL moves to MULT with count = 0 and latches a and b.
  - MULT: one iteration per edge. On the edge where count == WIDTH-1, load the outputs and CCR, pulse out_valid, return to IDLE.
- Stack is LIFO. Nested SAVE/SAVE/RTI/RTI restores snapshots in reverse order.

## Timing
- Reset (async, immediate):
  - state = IDLE, in_ready = 1, out_valid = 0.
  - result_lo = result_hi = 0, ccr = 0000, ccr_err = 0, stack empty.
- Non-MUL ops, accepted at edge t: outputs and ccr are registered at edge t. out_valid is high for exactly the one cycle after t.
- MUL, accepted at edge t:
  - in_ready is low for cycles t..t+WIDTH-1.
  - Outputs and out_valid appear after edge t+WIDTH-1+1 = t+WIDTH, i.e. latency WIDTH cycles.
  - in_ready returns high in the same cycle out_valid is high, so back-to-back issue is allowed.
- out_valid deasserts the cycle after a pulse. result_lo, result_hi and ccr hold until the next completion.
- No output backpressure: the consumer must sample on out_valid.
- in_valid while in_ready = 0 is ignored; the op is not queued.
- rst asserted during MULT aborts the multiply with no out_valid. CCR and stack clear.
- ccr_err clears only on reset.

## Test plan
- Reset, then ADD a=0x7FFF, b=0x0001 (WIDTH=16) -> next cycle: out_valid=1, result_lo=0x8000, ccr: NF=1, OF=1, CF=0, ZF=0.
- SUB a=0x0000, b=0x0001 -> result_lo=0xFFFF, CF=1, NF=1, OF=0. Then SHR a=0x0003, b=1 -> result_lo=0x0001, CF=1. Then SHL a=0x8001, b=20 -> result_lo=0, CF=0, ZF=1.
- MUL a=0xFFFF, b=0xFFFF -> in_ready low 16 cycles; out_valid in cycle 16 after accept with result_hi=0xFFFE, result_lo=0x0001, CF=1, NF=1. ADD held on in_valid during the stall is accepted only once in_ready=1.
- SETC, SAVE, CLRC, SAVE, SETC, RTI -> ccr.CF=0; RTI -> CF=1. A third RTI -> CCR unchanged, ccr_err=1. SAVE_DEPTH+1 consecutive SAVEs -> ccr_err=1.
- MUL accepted, rst pulsed 5 cycles later -> no out_valid; in_ready=1, ccr=0, result_lo/result_hi=0.
- Op code 25 with valid -> out_valid pulse, result 0, ccr unchanged.
